// File: rtl/fw_sweeper.sv
// fw_sweeper: programmable frequency-word sweep generator feeding ddfs.fw.
// Supports single up/down sweeps and continuous triangle/sawtooth chirps,
// with a per-word dwell time and output clamped to [fw_min, fw_max].
module fw_sweeper #(
   parameter int N = 8,
   parameter int D = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         stop,
   input  logic [1:0]   mode,
   input  logic [N-1:0] fw_min,
   input  logic [N-1:0] fw_max,
   input  logic [N-1:0] fw_step,
   input  logic [D-1:0] dwell,
   output logic [N-1:0] fw,
   output logic         fw_upd,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN_UP   = 2'd1,
      S_RUN_DOWN = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   localparam logic [1:0] M_SINGLE_UP = 2'd0;
   localparam logic [1:0] M_SINGLE_DN = 2'd1;
   localparam logic [1:0] M_TRIANGLE  = 2'd2;
   localparam logic [1:0] M_SAWTOOTH  = 2'd3;

   state_t       r_state, w_state_nxt;
   logic [N-1:0] r_fw, w_fw;
   logic         r_fw_upd, w_fw_upd;
   logic         r_done, w_done;
   logic         r_err, w_err;
   logic [D-1:0] r_cnt, w_cnt;
   logic [1:0]   r_mode, w_mode;
   logic [N-1:0] r_min, w_min;
   logic [N-1:0] r_max, w_max;
   logic [N-1:0] r_step, w_step;
   logic [D-1:0] r_dwell, w_dwell;
   logic         w_start_ok;

   // Up step in N+1 bits so a carry out of N bits saturates to hi instead of wrapping.
   function automatic logic [N-1:0] f_up_sat(input logic [N-1:0] a,
                                             input logic [N-1:0] step,
                                             input logic [N-1:0] hi);
      logic [N:0] s;
      s = {1'b0, a} + {1'b0, step};
      if (s > {1'b0, hi}) return hi;
      else                return s[N-1:0];
   endfunction

   // Down step in N+1 bits; a borrow (MSB set) or a result below lo clamps to lo.
   function automatic logic [N-1:0] f_dn_sat(input logic [N-1:0] a,
                                             input logic [N-1:0] step,
                                             input logic [N-1:0] lo);
      logic [N:0] d;
      d = {1'b0, a} - {1'b0, step};
      if (d[N] || (d[N-1:0] < lo)) return lo;
      else                         return d[N-1:0];
   endfunction

   // Stop has priority: a start arriving together with stop is dropped.
   assign w_start_ok = start && !stop && ((r_state == S_IDLE) || (r_state == S_DONE));

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_fw     <= '0;
         r_fw_upd <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
         r_mode   <= '0;
         r_min    <= '0;
         r_max    <= '0;
         r_step   <= '0;
         r_dwell  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_fw     <= w_fw;
         r_fw_upd <= w_fw_upd;
         r_done   <= w_done;
         r_err    <= w_err;
         r_cnt    <= w_cnt;
         r_mode   <= w_mode;
         r_min    <= w_min;
         r_max    <= w_max;
         r_step   <= w_step;
         r_dwell  <= w_dwell;
      end
   end

   // Next-state, next-word and pulse generation.
   always_comb begin
      w_state_nxt = r_state;
      w_fw        = r_fw;
      w_fw_upd    = 1'b0;
      w_done      = 1'b0;
      w_err       = r_err;
      w_cnt       = r_cnt;
      w_mode      = r_mode;
      w_min       = r_min;
      w_max       = r_max;
      w_step      = r_step;
      w_dwell     = r_dwell;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start_ok) begin
               w_mode  = mode;
               w_min   = fw_min;
               w_max   = fw_max;
               w_step  = fw_step;
               w_dwell = dwell;
               if ((fw_min > fw_max) || (fw_step == '0)) begin
                  // Bad config: report and park in DONE without touching fw.
                  w_state_nxt = S_DONE;
                  w_err       = 1'b1;
                  w_done      = 1'b1;
               end else begin
                  w_err    = 1'b0;
                  w_cnt    = dwell;
                  w_fw_upd = 1'b1;
                  if (mode == M_SINGLE_DN) begin
                     w_fw        = fw_max;
                     w_state_nxt = S_RUN_DOWN;
                  end else begin
                     w_fw        = fw_min;
                     w_state_nxt = S_RUN_UP;
                  end
               end
            end
         end

         S_RUN_UP: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt != '0) begin
               w_cnt = r_cnt - 1'b1;
            end else begin
               w_cnt = r_dwell;
               if (r_fw == r_max) begin
                  case (r_mode)
                     M_TRIANGLE: begin
                        // Turn around and take the first down step in the same cycle.
                        w_state_nxt = S_RUN_DOWN;
                        w_fw        = f_dn_sat(r_fw, r_step, r_min);
                     end
                     M_SAWTOOTH: begin
                        w_fw = r_min;
                     end
                     default: begin
                        w_state_nxt = S_DONE;
                        w_done      = 1'b1;
                     end
                  endcase
               end else begin
                  w_fw = f_up_sat(r_fw, r_step, r_max);
               end
               w_fw_upd = (w_fw != r_fw);
            end
         end

         S_RUN_DOWN: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt != '0) begin
               w_cnt = r_cnt - 1'b1;
            end else begin
               w_cnt = r_dwell;
               if (r_fw == r_min) begin
                  if (r_mode == M_TRIANGLE) begin
                     w_state_nxt = S_RUN_UP;
                     w_fw        = f_up_sat(r_fw, r_step, r_max);
                  end else begin
                     w_state_nxt = S_DONE;
                     w_done      = 1'b1;
                  end
               end else begin
                  w_fw = f_dn_sat(r_fw, r_step, r_min);
               end
               w_fw_upd = (w_fw != r_fw);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign fw     = r_fw;
   assign fw_upd = r_fw_upd;
   assign busy   = (r_state == S_RUN_UP) || (r_state == S_RUN_DOWN);
   assign done   = r_done;
   assign err    = r_err;

   // Single-up mode constant is named for readability of the mode decode.
   logic w_unused_mode_const;
   assign w_unused_mode_const = (M_SINGLE_UP == 2'd0);

endmodule
